// File: rtl/crop_video_ctrl_pkg.sv
// Register map, window type and window validation for the crop_video controller.
package crop_video_ctrl_pkg;

  localparam int CV_COORD_W = 12;
  localparam int CV_FCNT_W  = 16;

  localparam logic [2:0] ADDR_X0     = 3'd0;
  localparam logic [2:0] ADDR_Y0     = 3'd1;
  localparam logic [2:0] ADDR_W      = 3'd2;
  localparam logic [2:0] ADDR_H      = 3'd3;
  localparam logic [2:0] ADDR_IMG_W  = 3'd4;
  localparam logic [2:0] ADDR_IMG_H  = 3'd5;
  localparam logic [2:0] ADDR_CTRL   = 3'd6;
  localparam logic [2:0] ADDR_COMMIT = 3'd7;

  typedef struct packed {
    logic [CV_COORD_W-1:0] x0;
    logic [CV_COORD_W-1:0] y0;
    logic [CV_COORD_W-1:0] w;
    logic [CV_COORD_W-1:0] h;
    logic [CV_COORD_W-1:0] img_w;
    logic [CV_COORD_W-1:0] img_h;
  } crop_win_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  // One extra bit on the sums so x0+w cannot wrap past the image edge.
  function automatic logic win_valid(input crop_win_t win);
    logic [CV_COORD_W:0] x_end;
    logic [CV_COORD_W:0] y_end;
    x_end = {1'b0, win.x0} + {1'b0, win.w};
    y_end = {1'b0, win.y0} + {1'b0, win.h};
    return (win.w != '0) && (win.h != '0) &&
           (x_end <= {1'b0, win.img_w}) && (y_end <= {1'b0, win.img_h});
  endfunction

endpackage

// File: rtl/crop_video_ctrl_if.sv
// Config-agent write port plus the snooped AXI-Stream input handshake.
interface crop_video_ctrl_if #(
  parameter int COORD_W = 12
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [2:0]         cfg_addr;
  logic [COORD_W-1:0] cfg_wdata;
  logic               mon_valid;
  logic               mon_ready;
  logic               mon_user;
  logic               mon_last;

  modport master (
    output cfg_valid, cfg_addr, cfg_wdata,
    output mon_valid, mon_ready, mon_user, mon_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_wdata,
    input  mon_valid, mon_ready, mon_user, mon_last,
    output cfg_ready
  );
endinterface

// File: rtl/crop_video_frame_tracker.sv
// Follows frame position from AXIS beats; flags end of frame and SOF arriving mid-frame.
module crop_video_frame_tracker #(
  parameter int COORD_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mon_valid_i,
  input  logic               mon_ready_i,
  input  logic               mon_user_i,
  input  logic               mon_last_i,
  input  logic [COORD_W-1:0] img_h_i,
  output logic               eof_beat_o,
  output logic               in_frame_o,
  output logic               sync_err_o
);

  logic               in_frame_q, in_frame_d;
  logic               sync_err_q, sync_err_d;
  logic [COORD_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [COORD_W-1:0] line_cnt_q, line_cnt_d;
  logic               beat, sof_beat;
  logic [COORD_W-1:0] line_base;

  assign beat     = mon_valid_i & mon_ready_i;
  assign sof_beat = beat & mon_user_i;
  // An SOF beat restarts the line count before its own EOL is considered.
  assign line_base  = sof_beat ? '0 : line_cnt_q;
  assign eof_beat_o = beat & mon_last_i & (img_h_i != '0) &
                      (line_base == img_h_i - COORD_W'(1));

  always_comb begin
    in_frame_d = in_frame_q;
    sync_err_d = sync_err_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    if (sof_beat) begin
      sync_err_d = sync_err_q | in_frame_q | (pix_cnt_q != '0);
      in_frame_d = 1'b1;
    end
    if (beat) begin
      if (mon_last_i) begin
        pix_cnt_d = '0;
        if (eof_beat_o) begin
          in_frame_d = 1'b0;
          line_cnt_d = '0;
        end else begin
          line_cnt_d = line_base + COORD_W'(1);
        end
      end else begin
        pix_cnt_d = sof_beat ? COORD_W'(1) : pix_cnt_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_frame_q <= 1'b0;
      sync_err_q <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
    end else begin
      in_frame_q <= in_frame_d;
      sync_err_q <= sync_err_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
    end
  end

  assign in_frame_o = in_frame_q;
  assign sync_err_o = sync_err_q;

endmodule

// File: rtl/crop_video_ctrl.sv
// Shadow/active crop window registers; new windows reach the datapath only on frame boundaries.
// state   | meaning
// ST_IDLE | nothing applied yet, no frame geometry: a commit applies at once
// ST_RUN  | window active: a commit waits until between frames or the EOF beat
module crop_video_ctrl
  import crop_video_ctrl_pkg::*;
#(
  parameter int COORD_W = CV_COORD_W,
  parameter int FCNT_W  = CV_FCNT_W
) (
  input  logic               clk,
  input  logic               rst,
  crop_video_ctrl_if.slave   bus,
  output logic [COORD_W-1:0] crop_x0_o,
  output logic [COORD_W-1:0] crop_y0_o,
  output logic [COORD_W-1:0] crop_w_o,
  output logic [COORD_W-1:0] crop_h_o,
  output logic               crop_en_o,
  output logic               commit_pending_o,
  output logic               cfg_err_o,
  output logic               sync_err_o,
  output logic [FCNT_W-1:0]  frame_cnt_o
);

  ctrl_state_e       state_q, state_d;
  crop_win_t         shadow_q, shadow_d;
  crop_win_t         active_q, active_d;
  logic              shadow_en_q, shadow_en_d;
  logic              crop_en_q, crop_en_d;
  logic              pending_q, pending_d;
  logic              cfg_err_q, cfg_err_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic cfg_hs, apply, eof_beat, in_frame;

  crop_video_frame_tracker #(.COORD_W(COORD_W)) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .mon_valid_i (bus.mon_valid),
    .mon_ready_i (bus.mon_ready),
    .mon_user_i  (bus.mon_user),
    .mon_last_i  (bus.mon_last),
    .img_h_i     (active_q.img_h),
    .eof_beat_o  (eof_beat),
    .in_frame_o  (in_frame),
    .sync_err_o  (sync_err_o)
  );

  assign bus.cfg_ready = ~pending_q;
  assign cfg_hs        = bus.cfg_valid & ~pending_q;
  assign apply         = pending_q & ((state_q == ST_IDLE) | ~in_frame | eof_beat);

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    shadow_en_d = shadow_en_q;
    active_d    = active_q;
    crop_en_d   = crop_en_q;
    pending_d   = pending_q;
    cfg_err_d   = cfg_err_q;
    frame_cnt_d = frame_cnt_q;

    if (cfg_hs) begin
      case (bus.cfg_addr)
        ADDR_X0:    shadow_d.x0    = bus.cfg_wdata;
        ADDR_Y0:    shadow_d.y0    = bus.cfg_wdata;
        ADDR_W:     shadow_d.w     = bus.cfg_wdata;
        ADDR_H:     shadow_d.h     = bus.cfg_wdata;
        ADDR_IMG_W: shadow_d.img_w = bus.cfg_wdata;
        ADDR_IMG_H: shadow_d.img_h = bus.cfg_wdata;
        ADDR_CTRL:  shadow_en_d    = bus.cfg_wdata[0];
        default: begin
          // A disabling commit carries no window, so there is nothing to validate.
          if (!shadow_en_q || win_valid(shadow_q)) begin
            pending_d = 1'b1;
            cfg_err_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      endcase
    end

    if (apply) begin
      if (shadow_en_q) active_d = shadow_q;
      crop_en_d   = shadow_en_q;
      pending_d   = 1'b0;
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      state_d     = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      shadow_en_q <= 1'b0;
      active_q    <= '0;
      crop_en_q   <= 1'b0;
      pending_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      shadow_en_q <= shadow_en_d;
      active_q    <= active_d;
      crop_en_q   <= crop_en_d;
      pending_q   <= pending_d;
      cfg_err_q   <= cfg_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign crop_x0_o        = active_q.x0;
  assign crop_y0_o        = active_q.y0;
  assign crop_w_o         = active_q.w;
  assign crop_h_o         = active_q.h;
  assign crop_en_o        = crop_en_q;
  assign commit_pending_o = pending_q;
  assign cfg_err_o        = cfg_err_q;
  assign frame_cnt_o      = frame_cnt_q;

endmodule
